// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for a two-requester register file, with a pending-write
// scoreboard used for source-operand hazard detection.
module rf_wb_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [ADDR_W-1:0]        req0_reg,
   input  logic [DATA_W-1:0]        req0_data,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [ADDR_W-1:0]        req1_reg,
   input  logic [DATA_W-1:0]        req1_data,
   input  logic                     rsv_valid,
   input  logic [ADDR_W-1:0]        rsv_reg,
   input  logic [ADDR_W-1:0]        rs1_addr,
   input  logic [ADDR_W-1:0]        rs2_addr,
   output logic                     hazard1,
   output logic                     hazard2,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        WriteReg,
   output logic [DATA_W-1:0]        WriteData,
   output logic [(2**ADDR_W)-1:0]   pending,
   output logic                     err_unreserved
);

   localparam int NREG = 2**ADDR_W;

   logic                 r_prio;
   logic                 r_regwrite;
   logic [ADDR_W-1:0]    r_wreg;
   logic [DATA_W-1:0]    r_wdata;
   logic [NREG-1:0]      r_pending;
   logic                 r_err;

   logic                 w_grant0;
   logic                 w_grant1;
   logic                 w_accept;
   logic [ADDR_W-1:0]    w_sel_reg;
   logic [DATA_W-1:0]    w_sel_data;
   logic [NREG-1:0]      w_pend_next;
   logic                 w_rsv_same;
   logic                 w_unreserved;

   // Handshake: a requester's write is taken on a posedge where its valid and
   // ready are both high; ready is never high without valid, and only one
   // requester sees ready in any cycle (prio breaks the tie, 0 -> req0).
   assign w_grant0   = req0_valid & (~req1_valid | ~r_prio);
   assign w_grant1   = req1_valid & (~req0_valid |  r_prio);
   assign w_accept   = w_grant0 | w_grant1;
   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   assign w_sel_reg  = w_grant1 ? req1_reg  : req0_reg;
   assign w_sel_data = w_grant1 ? req1_data : req0_data;

   assign w_rsv_same   = rsv_valid & (rsv_reg == w_sel_reg);
   assign w_unreserved = w_accept & ~r_pending[w_sel_reg] & ~w_rsv_same;

   // Clear first, then set, so a same-edge reservation wins over the write.
   always_comb begin
      w_pend_next = r_pending;
      if (w_accept) begin
         w_pend_next[w_sel_reg] = 1'b0;
      end
      if (rsv_valid) begin
         w_pend_next[rsv_reg] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_prio     <= 1'b0;
         r_regwrite <= 1'b0;
         r_wreg     <= '0;
         r_wdata    <= '0;
         r_pending  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_regwrite <= w_accept;
         if (w_accept) begin
            r_wreg  <= w_sel_reg;
            r_wdata <= w_sel_data;
         end
         if (w_grant0) begin
            r_prio <= 1'b1;
         end else if (w_grant1) begin
            r_prio <= 1'b0;
         end
         r_pending <= w_pend_next;
         if (w_unreserved) begin
            r_err <= 1'b1;
         end
      end
   end

   assign hazard1        = r_pending[rs1_addr];
   assign hazard2        = r_pending[rs2_addr];
   assign RegWrite       = r_regwrite;
   assign WriteReg       = r_wreg;
   assign WriteData      = r_wdata;
   assign pending        = r_pending;
   assign err_unreserved = r_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, checked by
// a queue-based scoreboard against a behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int NREG   = 8;
   localparam int W      = ADDR_W + DATA_W;

   // ---------------- clock / reset ----------------
   logic                clock = 1'b0;
   logic                resetn;
   logic                req0_valid, req0_ready, req1_valid, req1_ready;
   logic [ADDR_W-1:0]   req0_reg, req1_reg, rsv_reg, rs1_addr, rs2_addr;
   logic [DATA_W-1:0]   req0_data, req1_data;
   logic                rsv_valid, hazard1, hazard2;
   logic                RegWrite, err_unreserved;
   logic [ADDR_W-1:0]   WriteReg;
   logic [DATA_W-1:0]   WriteData;
   logic [NREG-1:0]     pending;

   always #5 clock = ~clock;

   rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .resetn(resetn),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_reg(req0_reg), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_reg(req1_reg), .req1_data(req1_data),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .hazard1(hazard1), .hazard2(hazard2),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .pending(pending), .err_unreserved(err_unreserved)
   );

   // ---------------- scoreboard state / reference model ----------------
   int                  n_checks = 0;
   int                  n_fail   = 0;
   logic [W-1:0]        exp_q[$];
   bit                  m_pend[NREG];
   bit                  m_err;
   int                  m_prio;
   logic                obs_rdy0, obs_rdy1;
   logic [ADDR_W-1:0]   mon_last_reg;
   logic [DATA_W-1:0]   mon_last_data;
   logic [W-1:0]        mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [NREG-1:0] model_pending();
      logic [NREG-1:0] p;
      for (int i = 0; i < NREG; i++) p[i] = m_pend[i];
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      m_err  = 1'b0;
      m_prio = 0;
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   task automatic drive_cycle(
      input logic v0, input logic [ADDR_W-1:0] g0, input logic [DATA_W-1:0] d0,
      input logic v1, input logic [ADDR_W-1:0] g1, input logic [DATA_W-1:0] d1,
      input logic rv, input logic [ADDR_W-1:0] rr,
      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
      int                winner;
      logic [ADDR_W-1:0] wr;
      logic [DATA_W-1:0] wd;
      @(negedge clock);
      req0_valid = v0; req0_reg = g0; req0_data = d0;
      req1_valid = v1; req1_reg = g1; req1_data = d1;
      rsv_valid  = rv; rsv_reg  = rr;
      rs1_addr   = a1; rs2_addr = a2;
      #1;
      if (v0 && v1)  winner = m_prio;
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
      else           winner = -1;
      obs_rdy0 = req0_ready;
      obs_rdy1 = req1_ready;
      chk("req0_ready", 32'(req0_ready), 32'(winner == 0));
      chk("req1_ready", 32'(req1_ready), 32'(winner == 1));
      chk("hazard1",    32'(hazard1),    32'(m_pend[a1]));
      chk("hazard2",    32'(hazard2),    32'(m_pend[a2]));
      if (winner >= 0) begin
         wr = (winner == 1) ? g1 : g0;
         wd = (winner == 1) ? d1 : d0;
         exp_q.push_back({wr, wd});
         if (!m_pend[wr] && !(rv && rr == wr)) m_err = 1'b1;
         m_pend[wr] = 1'b0;
         m_prio = 1 - winner;
      end
      if (rv) m_pend[rr] = 1'b1;
      @(posedge clock);
   endtask

   task automatic idle_cycle();
      drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (!resetn) begin
         mon_last_reg  = '0;
         mon_last_data = '0;
      end else begin
         chk("RegWrite", 32'(RegWrite), 32'(exp_q.size() != 0));
         if (RegWrite && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("WriteReg",  32'(WriteReg),  32'(mon_e[W-1:DATA_W]));
            chk("WriteData", 32'(WriteData), 32'(mon_e[DATA_W-1:0]));
            mon_last_reg  = mon_e[W-1:DATA_W];
            mon_last_data = mon_e[DATA_W-1:0];
         end else if (!RegWrite) begin
            chk("WriteReg_hold",  32'(WriteReg),  32'(mon_last_reg));
            chk("WriteData_hold", 32'(WriteData), 32'(mon_last_data));
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         chk("pending",        32'(pending),        32'(model_pending()));
         chk("err_unreserved", 32'(err_unreserved), 32'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   int exp_g[4] = '{0, 1, 0, 1};

   initial begin
      resetn = 1'b0;
      req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
      req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
      rsv_valid  = 1'b0; rsv_reg  = '0;
      rs1_addr   = '0;   rs2_addr = '0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("rst_RegWrite",  32'(RegWrite),       32'd0);
      chk("rst_WriteReg",  32'(WriteReg),       32'd0);
      chk("rst_WriteData", 32'(WriteData),      32'd0);
      chk("rst_pending",   32'(pending),        32'd0);
      chk("rst_err",       32'(err_unreserved), 32'd0);
      @(negedge clock);
      #1 resetn = 1'b1;

      // basic reserve + write
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3, 3'd0);
      drive_cycle(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd0);
      #1;
      chk("t1_ready0",    32'(obs_rdy0),   32'd1);
      chk("t1_pending3",  32'(pending[3]), 32'd0);
      chk("t1_RegWrite",  32'(RegWrite),   32'd1);
      chk("t1_WriteReg",  32'(WriteReg),   32'd3);
      chk("t1_WriteData", 32'(WriteData),  32'h1234);

      // bring prio back to 0 with a lone req1 grant, then alternate grants
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd7, 3'd0);
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 3'd7, 3'd0);
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1, 3'd2);
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd1, 3'd2);
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555,
                     (k < 2) ? 1'b1 : 1'b0, (k == 0) ? 3'd1 : 3'd2, 3'd1, 3'd2);
         chk("t2_ready0",   32'(obs_rdy0), 32'(exp_g[k] == 0));
         chk("t2_ready1",   32'(obs_rdy1), 32'(exp_g[k] == 1));
         chk("t2_onehot",   32'(obs_rdy0 & obs_rdy1), 32'd0);
      end
      #1;
      chk("t2_err", 32'(err_unreserved), 32'd0);

      // reservation and write of the same register on one edge
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 3'd0);
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h0505, 1'b1, 3'd5, 3'd5, 3'd0);
      #1;
      chk("t3_pending5", 32'(pending[5]), 32'd1);
      chk("t3_hazard1",  32'(hazard1),    32'd1);

      // write to an unreserved register
      drive_cycle(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd5);
      #1;
      chk("t4_err",      32'(err_unreserved), 32'd1);
      chk("t4_RegWrite", 32'(RegWrite),       32'd1);
      chk("t4_WriteReg", 32'(WriteReg),       32'd6);
      idle_cycle();
      idle_cycle();
      #1;
      chk("t4_err_sticky", 32'(err_unreserved), 32'd1);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         drive_cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                     1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                     1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                     ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      end

      // reset right after an accept: the in-flight write must vanish
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd4, 3'd0);
      drive_cycle(1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd0);
      #2 resetn = 1'b0;
      #1;
      chk("t5_RegWrite",  32'(RegWrite),       32'd0);
      chk("t5_WriteReg",  32'(WriteReg),       32'd0);
      chk("t5_WriteData", 32'(WriteData),      32'd0);
      chk("t5_pending",   32'(pending),        32'd0);
      chk("t5_err",       32'(err_unreserved), 32'd0);
      model_reset();
      rsv_valid = 1'b1; rsv_reg = 3'd2;
      repeat (2) @(posedge clock);
      #1;
      chk("t5_rst_pending",  32'(pending),  32'd0);
      chk("t5_rst_RegWrite", 32'(RegWrite), 32'd0);
      @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
      #1 resetn = 1'b1;
      idle_cycle();
      idle_cycle();

      // first acceptance right after reset release
      drive_cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h0C0D, 1'b1, 3'd0, 3'd0, 3'd0);
      #1;
      chk("t6_RegWrite",  32'(RegWrite),  32'd1);
      chk("t6_WriteData", 32'(WriteData), 32'h0C0D);
      idle_cycle();
      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
